addsub_seq: RTL and testbench
=============================

# addsub_seq

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, through a single CHUNK-bit ripple-carry slice. It replaces the fixed 4-bit combinational add/sub in datapaths where area matters more than latency. It reports carry, signed overflow and zero, and uses a start/busy/done handshake toward the controlling FSM.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. NCH = WIDTH/CHUNK.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- cin  input  1  add: carry-in; subtract: borrow-in; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  operation in progress; start ignored.
- done  output  1  one-cycle pulse, result valid.
- s  output  WIDTH  result.
- cout  output  1  raw carry out of MSB slice.
- ovf  output  1  two's-complement overflow.
- zero  output  1  s == 0.

## Operation
- Arithmetic: add → s = a + b + cin; subtract → s = a + ~b + ~cin (i.e. a − b − cin), all modulo 2^WIDTH.
- cout: add → 1 on unsigned carry; subtract → 1 means no borrow.
- ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- FSM states IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b XOR {WIDTH{sub}}, carry = cin XOR sub, slice index 0; go RUN. start=0 → stay.
- RUN: compute slice at current index from latched operands and carry; write slice into internal accumulator; update carry; increment index. After slice NCH−1 → DONE.
- DONE: done=1 for this cycle only. start=1 → capture as in IDLE, go RUN; else → IDLE.
- Outputs s, cout, ovf, zero update only on the RUN→DONE edge and then hold until the next completion. Intermediate slices are never visible.
- start while busy=1: ignored, no effect on the operation in flight. Input changes after capture have no effect.

## Timing
- Reset: state IDLE; busy=0, done=0, s=0, cout=0, ovf=0, zero=0; internal index/carry cleared. Reset wins over start in the same cycle.
- start sampled at edge E0 → busy=1 from E0 through E_NCH; outputs and done=1 valid after E_NCH; busy=0 in the done cycle.
- Latency start→done = NCH cycles. Back-to-back: start during the done cycle gives a throughput of one result per NCH+1 cycles.
- NCH=1 (CHUNK=WIDTH): RUN lasts one cycle; done follows one cycle after start.
- Reset mid-RUN: operation aborted, no done pulse, outputs return to 0.

## Test plan
- WIDTH=8, CHUNK=4: add a=100, b=27, cin=0 → done exactly 2 cycles after start; s=127, cout=0, ovf=0, zero=0; busy high for 2 cycles.
- add a=0x7F, b=0x01 → s=0x80, ovf=1, cout=0. add a=0xFF, b=0x00, cin=1 → s=0x00, cout=1, zero=1, ovf=0.
- sub a=5, b=5, cin=0 → s=0, zero=1, cout=1. sub a=3, b=5 → s=0xFE, cout=0, ovf=0. sub a=0x80, b=0x01 → s=0x7F, ovf=1.
- start pulsed with different operands while busy → ignored; first result unchanged. New start in the done cycle → accepted; second done 2 cycles later.
- rst asserted in the second RUN cycle → no done pulse; all outputs 0 next cycle. start in the same cycle as rst → ignored.
- WIDTH=16, CHUNK=1: 0x1234 + 0x0FCD → s=0x2201, done 16 cycles after start. Random add/sub vectors checked against a reference model in both configurations.

Source files
------------

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle adder/subtractor that walks a WIDTH-bit operation
// through a single CHUNK-bit ripple slice, one slice per clock, with a
// start/busy/done handshake and carry/overflow/zero flags.
module addsub_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SW   = CHUNK + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CHUNK-1:0]  a_sl;
  logic [CHUNK-1:0]  b_sl;
  logic [SW-1:0]     sl_sum;
  logic              last_sl;
  logic              capture;
  logic [WIDTH-1:0]  result;

  // Select the current operand slices and run them through the ripple slice
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
    sl_sum  = SW'(a_sl) + SW'(b_sl) + SW'(carry_q);
    last_sl = (idx_q == IDXW'(NCH - 1));
  end

  // State register; reset dominates any start in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_sl) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; subtraction is folded into capture by
  // inverting b and the incoming borrow so RUN is always a plain add
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    capture = start && (state_q != S_RUN);

    result = acc_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (idx_q == IDXW'(i)) begin
        result[i*CHUNK +: CHUNK] = sl_sum[CHUNK-1:0];
      end
    end

    if (capture) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = cin ^ sub;
      idx_d   = '0;
      acc_d   = '0;
    end else if (state_q == S_RUN) begin
      acc_d   = result;
      carry_d = sl_sum[CHUNK];
      idx_d   = idx_q + IDXW'(1);
      if (last_sl) begin
        idx_d  = '0;
        s_d    = result;
        cout_d = sl_sum[CHUNK];
        // carry into the MSB recovered from the MSB sum bit
        ovf_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ result[WIDTH-1] ^ sl_sum[CHUNK];
        zero_d = (result == '0);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: an 8/4 instance and a 16/1 instance, each with a
// scoreboard queue filled at issue time and drained by a done-driven monitor.
module tb_addsub_seq;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  s8;

  logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16, zero16;
  logic [15:0] s16;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_seq #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .s(s8),
    .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  addsub_seq #(.WIDTH(16), .CHUNK(1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .cin(cin16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .s(s16),
    .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for s/cout, signed for ovf
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic sb, input logic ci, input int ec);
    exp_t   e;
    longint m, half, ua, ub, sa, sbv, full, r;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(av) & (m - 1);
    ub   = longint'(bv) & (m - 1);
    sa   = (ua >= half) ? ua - m : ua;
    sbv  = (ub >= half) ? ub - m : ub;
    if (!sb) begin
      full   = ua + ub + longint'(ci);
      r      = sa + sbv + longint'(ci);
      e.cout = (full >= m);
    end else begin
      full   = ua - ub - longint'(ci);
      r      = sa - sbv - longint'(ci);
      e.cout = (full >= 0);
    end
    e.s    = 16'(full & (m - 1));
    e.zero = ((full & (m - 1)) == 0);
    e.ovf  = (r < -half) || (r >= half);
    e.cyc  = ec;
    return e;
  endfunction

  // Drive one start pulse at the current negedge; push the expectation if it should be accepted
  task automatic issue(input int w, input logic [15:0] av, input logic [15:0] bv,
                       input logic sb, input logic ci, input bit push);
    if (w == 8) begin
      a8 = av[7:0]; b8 = bv[7:0]; sub8 = sb; cin8 = ci; start8 = 1'b1;
      if (push) q8.push_back(model(8, av, bv, sb, ci, cyc + 1 + 2));
    end else begin
      a16 = av; b16 = bv; sub16 = sb; cin16 = ci; start16 = 1'b1;
      if (push) q16.push_back(model(16, av, bv, sb, ci, cyc + 1 + 16));
    end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); cin16 = 1'($urandom);
  endtask

  task automatic wait_done(input int w);
    int n = 0;
    while (((w == 8) ? done8 : done16) !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 32'((w == 8) ? done8 : done16), 32'(1));
  endtask

  task automatic wait_idle(input int w);
    int n = 0;
    while (((w == 8) ? (busy8 | done8) : (busy16 | done16)) !== 1'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'((w == 8) ? (busy8 | done8) : (busy16 | done16)), 32'(0));
  endtask

  // Monitors: pop on every done pulse and compare result, flags and latency
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) chk("dut8_unexpected_done", 32'(done8), 32'(0));
      else begin
        e8 = q8.pop_front();
        chk("dut8_s", 32'(s8), 32'(e8.s));
        chk("dut8_cout", 32'(cout8), 32'(e8.cout));
        chk("dut8_ovf", 32'(ovf8), 32'(e8.ovf));
        chk("dut8_zero", 32'(zero8), 32'(e8.zero));
        chk("dut8_latency", 32'(cyc), 32'(e8.cyc));
        chk("dut8_busy_in_done", 32'(busy8), 32'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (done16 === 1'b1) begin
      if (q16.size() == 0) chk("dut16_unexpected_done", 32'(done16), 32'(0));
      else begin
        e16 = q16.pop_front();
        chk("dut16_s", 32'(s16), 32'(e16.s));
        chk("dut16_cout", 32'(cout16), 32'(e16.cout));
        chk("dut16_ovf", 32'(ovf16), 32'(e16.ovf));
        chk("dut16_zero", 32'(zero16), 32'(e16.zero));
        chk("dut16_latency", 32'(cyc), 32'(e16.cyc));
        chk("dut16_busy_in_done", 32'(busy16), 32'(0));
      end
    end
  end

  // Directed vectors for the 8/4 instance: a, b, sub, cin, then held s, cout, ovf, zero
  logic [7:0] va [6] = '{8'd100, 8'h7F, 8'hFF, 8'd5, 8'd3, 8'h80};
  logic [7:0] vb [6] = '{8'd27,  8'h01, 8'h00, 8'd5, 8'd5, 8'h01};
  logic       vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] xs [6] = '{8'h7F, 8'h80, 8'h00, 8'h00, 8'hFE, 8'h7F};
  logic       xc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       xo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       xz [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'(0));
    chk("rst_done8", 32'(done8), 32'(0));
    chk("rst_s8", 32'(s8), 32'(0));
    chk("rst_flags8", 32'({cout8, ovf8, zero8}), 32'(0));
    chk("rst_s16", 32'(s16), 32'(0));
    chk("rst_busy16", 32'(busy16), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // first vector with explicit busy/done cycle profile
    issue(8, 16'(va[0]), 16'(vb[0]), vs[0], vc[0], 1'b1);
    chk("busy_cycle1", 32'({busy8, done8}), 32'(2'b10));
    @(negedge clk);
    chk("busy_cycle2", 32'({busy8, done8}), 32'(2'b10));
    @(negedge clk);
    chk("done_cycle", 32'({busy8, done8}), 32'(2'b01));
    wait_idle(8);
    chk("held_s_0", 32'(s8), 32'(xs[0]));

    for (int i = 1; i < 6; i++) begin
      issue(8, 16'(va[i]), 16'(vb[i]), vs[i], vc[i], 1'b1);
      wait_idle(8);
      chk($sformatf("held_s_%0d", i), 32'(s8), 32'(xs[i]));
      chk($sformatf("held_flags_%0d", i), 32'({cout8, ovf8, zero8}), 32'({xc[i], xo[i], xz[i]}));
    end

    // start while busy is ignored; start in the done cycle is accepted
    issue(8, 16'd10, 16'd20, 1'b0, 1'b0, 1'b1);
    issue(8, 16'hAA, 16'h55, 1'b1, 1'b1, 1'b0);
    wait_done(8);
    chk("ignored_start_result", 32'(s8), 32'(30));
    issue(8, 16'h33, 16'h44, 1'b0, 1'b1, 1'b1);
    wait_idle(8);
    chk("b2b_result", 32'(s8), 32'(8'h78));

    // reset in the second RUN cycle aborts; a start alongside reset is dropped
    issue(8, 16'h12, 16'h34, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    chk("abort_busy", 32'(busy8), 32'(0));
    chk("abort_done", 32'(done8), 32'(0));
    chk("abort_s", 32'(s8), 32'(0));
    chk("abort_flags", 32'({cout8, ovf8, zero8}), 32'(0));
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", 32'({busy8, done8}), 32'(0));

    // random 8/4 traffic, sometimes back-to-back in the done cycle
    for (int i = 0; i < 40; i++) begin
      issue(8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      wait_done(8);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    wait_idle(8);

    // 16/1 instance: directed then random
    issue(16, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b1);
    wait_idle(16);
    chk("w16_directed", 32'(s16), 32'(16'h2201));
    for (int i = 0; i < 30; i++) begin
      issue(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      wait_done(16);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    wait_idle(16);

    repeat (2) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'(0));
    chk("q16_drained", 32'(q16.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
